div_s4_bits: RTL

Sequential signed 4-bit divider that inverts the signed 4-bit multiplier datapath. It computes a two's-complement quotient and remainder from a 4-bit dividend and a 4-bit divisor using sign-magnitude restoring division, one quotient bit per cycle. A start/busy/done handshake connects it to the arithmetic unit.

---
 rtl/div_s4_pkg.sv | 21 ++
 rtl/div_u4_step.sv | 25 ++
 rtl/div_s4_bits.sv | 139 +++++++++++++
 3 files changed

// File: rtl/div_s4_pkg.sv
// Shared constants and helpers for the signed 4-bit sequential divider.
// The optional divide-by-zero early exit is controlled by DIV_S4_BITS_DBZ_EN.
package div_s4_pkg;

  localparam int unsigned W = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  // Two's-complement negate, truncated to W bits.
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
    return (~v) + W'(1);
  endfunction

  // Magnitude of a signed W-bit value; |-8| wraps to 4'b1000, read as unsigned.
  function automatic logic [W-1:0] abs_w(input logic [W-1:0] v);
    return v[W-1] ? neg_w(v) : v;
  endfunction

endpackage

// File: rtl/div_u4_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// Shifts the next dividend bit into the partial remainder and subtracts the divisor if it fits.
module div_u4_step
  import div_s4_pkg::*;
(
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] dvs_ext;

  // The partial remainder stays below |y| <= 8, so its top bit is always zero before the shift.
  assign shifted = {rem_i[W-1:0], bit_i};
  assign dvs_ext = {1'b0, dvs_i};

  always_comb begin
    q_o   = (shifted >= dvs_ext);
    rem_o = q_o ? (shifted - dvs_ext) : shifted;
  end

endmodule

// File: rtl/div_s4_bits.sv
// Sequential signed 4-bit divider: sign-magnitude restoring division, one quotient bit per cycle.
// Define DIV_S4_BITS_DBZ_EN to flag a zero divisor and complete early with dbz set.
module div_s4_bits
  import div_s4_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         ovf,
  output logic         dbz
);

  logic [1:0]   state_q, state_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic [W-1:0] xm_q, xm_d;   // |x| shifting out MSB-first, quotient bits shifting in
  logic [W:0]   prem_q, prem_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] quot_q, quot_d;
  logic [W-1:0] rem_q, rem_d;
  logic         ovf_q, ovf_d;
  logic         dbz_q, dbz_d;
  logic         done_q, done_d;

  logic [W:0]   step_rem;
  logic         step_q;
  logic [W-1:0] rmag;

  div_u4_step u_step (
    .rem_i (prem_q),
    .bit_i (xm_q[W-1]),
    .dvs_i (abs_w(y_q)),
    .rem_o (step_rem),
    .q_o   (step_q)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    xm_d    = xm_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    // A zero divisor would leave |x| in the remainder; the defined result is zero.
    rmag    = (y_q == '0) ? '0 : prem_q[W-1:0];

    case (state_q)
      StIdle: begin
        if (start) begin
          x_d     = x;
          y_d     = y;
          xm_d    = abs_w(x);
          prem_d  = '0;
          cnt_d   = '0;
          state_d = StCalc;
`ifdef DIV_S4_BITS_DBZ_EN
          if (y == '0) begin
            state_d = StFix;
          end
`endif
        end
      end
      StCalc: begin
        prem_d = step_rem;
        xm_d   = {xm_q[W-2:0], step_q};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = StFix;
        end
      end
      StFix: begin
        done_d  = 1'b1;
        state_d = StIdle;
        quot_d  = (x_q[W-1] ^ y_q[W-1]) ? neg_w(xm_q) : xm_q;
        rem_d   = x_q[W-1] ? neg_w(rmag) : rmag;
        ovf_d   = (x_q == 4'h8) && (y_q == 4'hF);
        dbz_d   = 1'b0;
`ifdef DIV_S4_BITS_DBZ_EN
        if (y_q == '0) begin
          quot_d = '0;
          rem_d  = x_q;
          ovf_d  = 1'b0;
          dbz_d  = 1'b1;
        end
`endif
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      xm_q    <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      xm_q    <= xm_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;

endmodule
